// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared widths, timeout default and FSM state type for the memory initiator.
package mem_if_pkg;
  localparam int ADDR_W_DEF  = 7;
  localparam int DATA_W_DEF  = 8;
  localparam int MEM_TIMEOUT = 16;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RELEASE} state_t;
endpackage

// File: rtl/memory_master.sv
// memory_master: sequences one memory access per CPU request (setup, enable until ready, release).
// Optional MEM_TIMEOUT_EN bounds the ACCESS wait and reports resp_error on expiry.
module memory_master
  import mem_if_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = MEM_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic              mem_en,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_input_data,
  input  logic [DATA_W-1:0] mem_output_data,
  input  logic              mem_ready
);
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  state_t state;
  logic expire;
`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic timed_out;
  assign expire = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
`else
  assign expire = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_error     <= 1'b0;
      mem_en         <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_input_data <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt            <= '0;
      timed_out      <= 1'b0;
`endif
    end else begin
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          mem_read       <= !req_write;
          mem_write      <= req_write;
          mem_address    <= req_addr;
          mem_input_data <= req_wdata;
          req_ready      <= 1'b0;
          state          <= SETUP;
        end
        SETUP: begin
          mem_en <= 1'b1;
          state  <= ACCESS;
`ifdef MEM_TIMEOUT_EN
          cnt       <= '0;
          timed_out <= 1'b0;
`endif
        end
        ACCESS: if (mem_ready || expire) begin
          mem_en <= 1'b0;
          state  <= RELEASE;
          if (mem_ready && !mem_write) resp_rdata <= mem_output_data;
`ifdef MEM_TIMEOUT_EN
          timed_out <= !mem_ready;
        end else begin
          cnt <= cnt + 1'b1;
`endif
        end
        RELEASE: if (!mem_ready) begin
          resp_valid <= 1'b1;
`ifdef MEM_TIMEOUT_EN
          resp_error <= timed_out;
`endif
          mem_read   <= 1'b0;
          mem_write  <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_master.sv
// tb_memory_master: randomized self-checking bench with a behavioural memory responder and reference memory.
module tb_memory_master;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       resp_valid, resp_error;
  logic [7:0] resp_rdata;
  logic       mem_en, mem_read, mem_write;
  logic [6:0] mem_address;
  logic [7:0] mem_input_data, mem_output_data;
  logic       mem_ready = 1'b0;
  int checks = 0, failures = 0;
  memory_master dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_en(mem_en), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_input_data(mem_input_data),
    .mem_output_data(mem_output_data), .mem_ready(mem_ready)
  );
  always #5 clk = ~clk;
  // Memory responder: ready rises after `delay` enabled cycles, falls once en is released.
  logic [7:0] mem [128];
  logic [7:0] ref_mem [128];
  int en_cnt = 0, delay = 1;
  bit stuck = 0, never = 0;
  assign mem_output_data = mem_read ? mem[mem_address] : 8'h00;
  always @(negedge clk) begin
    if (mem_en && mem_write) mem[mem_address] = mem_input_data;
    en_cnt = mem_en ? en_cnt + 1 : 0;
    mem_ready = stuck || (!never && mem_en && en_cnt >= delay);
  end
  // Issues one request from a negedge with the block idle and observes the access until resp_valid.
  task automatic run_req(input bit w, input logic [6:0] a, input logic [7:0] d, input int budget,
                         output int lat, output bit got, output logic [7:0] rd, output bit er,
                         output bit setup_ok, output bit both, output int en_cyc);
    bit pe = 0, pw = 0, pr = 0;
    logic [6:0] pa = '0;
    int n = 0;
    lat = 0; got = 0; rd = 'x; er = 0; setup_ok = 1; both = 0; en_cyc = 0;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
    while (!req_ready && n < budget) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 0;
    for (int i = 1; i <= budget; i++) begin
      if (i > 1) @(negedge clk);
      lat = i;
      if (mem_read && mem_write) both = 1;
      if (mem_en) begin
        en_cyc++;
        if (mem_write !== w || mem_read !== !w || mem_address !== a) setup_ok = 0;
        if (!pe && (pw !== w || pr !== !w || pa !== a)) setup_ok = 0;
      end
      if (resp_valid) begin got = 1; rd = resp_rdata; er = resp_error; break; end
      pe = mem_en; pw = mem_write; pr = mem_read; pa = mem_address;
    end
  endtask
  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_error, mem_en, mem_read, mem_write} !== 6'b100000 || resp_rdata !== 8'h00) begin
      failures++;
      $display("FAIL reset_state got=%b/%h exp=100000/00", {req_ready, resp_valid, resp_error, mem_en, mem_read, mem_write}, resp_rdata);
    end
    reset = 0;
    @(negedge clk);
  endtask
  task automatic test_write_read();
    int lat, ec; bit got, er, sok, both; logic [7:0] rd;
    delay = 2;
    run_req(1, 7'd1, 8'hFF, 30, lat, got, rd, er, sok, both, ec);
    ref_mem[1] = 8'hFF;
    checks++;
    if (!got || er !== 0 || lat != 5) begin failures++; $display("FAIL write_resp got=%0b err=%0b lat=%0d exp=1 0 5", got, er, lat); end
    checks++;
    if (!sok || both || ec != 2) begin failures++; $display("FAIL write_seq setup=%0b both=%0b en_cycles=%0d exp=1 0 2", sok, both, ec); end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin failures++; $display("FAIL write_single_pulse got=%0b exp=0", resp_valid); end
    run_req(0, 7'd1, 8'h00, 30, lat, got, rd, er, sok, both, ec);
    checks++;
    if (!got || rd !== 8'hFF || er !== 0) begin failures++; $display("FAIL read_after_write got=%0b rdata=%h err=%0b exp=1 ff 0", got, rd, er); end
    checks++;
    if (!sok || both) begin failures++; $display("FAIL read_mode setup=%0b both=%0b exp=1 0", sok, both); end
    delay = 1;
    run_req(0, 7'd1, 8'h00, 30, lat, got, rd, er, sok, both, ec);
    checks++;
    if (!got || lat != 4) begin failures++; $display("FAIL min_latency got=%0b lat=%0d exp=1 4", got, lat); end
  endtask
  task automatic test_back_to_back();
    int n = 0; bit got = 0;
    delay = 1;
    req_valid = 1; req_write = 1; req_addr = 7'd3; req_wdata = 8'hA5;
    while (!req_ready && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    req_write = 0; req_wdata = 8'($urandom);
    for (int i = 0; i < 30 && !got; i++) begin
      if (resp_valid) got = 1; else @(negedge clk);
    end
    ref_mem[3] = 8'hA5;
    checks++;
    if (!got || req_ready !== 1'b1 || mem_en !== 1'b0) begin failures++; $display("FAIL b2b_first_resp got=%0b ready=%0b en=%0b exp=1 1 0", got, req_ready, mem_en); end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 7'd3 || mem_en !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept ready=%0b rd=%0b wr=%0b addr=%0d en=%0b exp=0 1 0 3 0", req_ready, mem_read, mem_write, mem_address, mem_en);
    end
    req_valid = 0;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (resp_valid) got = 1; else @(negedge clk);
    end
    checks++;
    if (!got || resp_rdata !== 8'hA5) begin failures++; $display("FAIL b2b_read got=%0b rdata=%h exp=1 a5", got, resp_rdata); end
    @(negedge clk);
  endtask
  task automatic test_reset_mid();
    int n = 0; bit seen = 0;
    delay = 10;
    req_valid = 1; req_write = 0; req_addr = 7'd1;
    while (!req_ready && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 0;
    for (int i = 0; i < 5 && !mem_en; i++) @(negedge clk);
    checks++;
    if (mem_en !== 1'b1) begin failures++; $display("FAIL reset_mid_access en=%0b exp=1", mem_en); end
    reset = 1;
    @(negedge clk);
    checks++;
    if (mem_en !== 0 || req_ready !== 1 || mem_read !== 0 || mem_write !== 0) begin
      failures++;
      $display("FAIL reset_mid_abort en=%0b ready=%0b rd=%0b wr=%0b exp=0 1 0 0", mem_en, req_ready, mem_read, mem_write);
    end
    reset = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (resp_valid) seen = 1; end
    checks++;
    if (seen) begin failures++; $display("FAIL reset_mid_no_resp got=1 exp=0"); end
    delay = 1;
  endtask
  task automatic test_timeout();
    int lat, ec; bit got, er, sok, both; logic [7:0] rd, prev;
    prev = resp_rdata;
    never = 1;
`ifdef MEM_TIMEOUT_EN
    run_req(0, 7'd1, 8'h00, 40, lat, got, rd, er, sok, both, ec);
    checks++;
    if (!got || er !== 1'b1 || ec != 16) begin failures++; $display("FAIL timeout_resp got=%0b err=%0b en_cycles=%0d exp=1 1 16", got, er, ec); end
    checks++;
    if (rd !== prev) begin failures++; $display("FAIL timeout_rdata got=%h exp=%h", rd, prev); end
`else
    run_req(0, 7'd1, 8'h00, 40, lat, got, rd, er, sok, both, ec);
    checks++;
    if (got || mem_en !== 1'b1 || ec < 35) begin failures++; $display("FAIL no_timeout got=%0b en=%0b en_cycles=%0d exp=0 1 >=35", got, mem_en, ec); end
    reset = 1;
    @(negedge clk);
    reset = 0;
`endif
    never = 0;
    @(negedge clk);
    checks++;
    if (resp_error !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL timeout_recover err=%0b ready=%0b exp=0 1", resp_error, req_ready); end
  endtask
  task automatic test_stuck_ready();
    int n = 0, ec = 0; bit got = 0, early = 0;
    stuck = 1;
    req_valid = 1; req_write = 0; req_addr = 7'd3;
    while (!req_ready && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_en) ec++;
      if (resp_valid) early = 1;
      @(negedge clk);
    end
    checks++;
    if (early || ec != 1) begin failures++; $display("FAIL stuck_hold resp=%0b en_cycles=%0d exp=0 1", early, ec); end
    stuck = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      if (mem_en) ec++;
      if (resp_valid) got = 1; else @(negedge clk);
    end
    checks++;
    if (!got || resp_rdata !== ref_mem[3] || ec != 1) begin failures++; $display("FAIL stuck_release got=%0b rdata=%h en_cycles=%0d exp=1 %h 1", got, resp_rdata, ec, ref_mem[3]); end
    @(negedge clk);
  endtask
  task automatic test_random();
    int lat, ec, bad = 0; bit got, er, sok, both, w; logic [7:0] rd, d; logic [6:0] a;
    for (int k = 0; k < 24; k++) begin
      delay = $urandom_range(1, 4);
      w = 1'($urandom);
      a = 7'($urandom_range(0, 15));
      d = 8'($urandom);
      run_req(w, a, d, 30, lat, got, rd, er, sok, both, ec);
      checks++;
      if (!got || er || lat != 3 + delay || !sok || both || (!w && rd !== ref_mem[a])) begin
        failures++; bad++;
        $display("FAIL random_%0d w=%0b a=%0d got=%0b err=%0b lat=%0d exp_lat=%0d setup=%0b both=%0b rdata=%h exp=%h",
                 k, w, a, got, er, lat, 3 + delay, sok, both, rd, ref_mem[a]);
      end
      if (w) ref_mem[a] = d;
      @(negedge clk);
    end
    for (int i = 0; i < 16; i++) begin
      run_req(0, 7'(i), 8'h00, 30, lat, got, rd, er, sok, both, ec);
      checks++;
      if (!got || rd !== ref_mem[i]) begin failures++; $display("FAIL sweep_%0d got=%0b rdata=%h exp=%h", i, got, rd, ref_mem[i]); end
    end
    delay = 1;
  endtask
  initial begin
    for (int i = 0; i < 128; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    @(negedge clk);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    test_stuck_ready();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/memory_master.md
Name: memory_master

Overview:
- Initiator for the `memory` block's en/read/write/address/input_data/output_data/ready interface.
- Accepts single-word read/write requests from the CPU datapath over a valid/ready handshake.
- Sequences the memory control lines (mode and address set up first, then en asserted until ready, then en released) and returns read data with a one-cycle response pulse.

Parameters:
- ADDR_W, 7, memory address width
- DATA_W, 8, memory data width
- TIMEOUT_CYCLES, 16, maximum cycles in ACCESS waiting for mem_ready (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  CPU request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  one-cycle pulse: access complete
- resp_rdata  out  DATA_W  read data, valid with resp_valid on reads
- resp_error  out  1  timeout flag, valid with resp_valid
- mem_en  out  1  to memory en
- mem_read  out  1  to memory read
- mem_write  out  1  to memory write
- mem_address  out  ADDR_W  to memory address
- mem_input_data  out  DATA_W  to memory input_data
- mem_output_data  in  DATA_W  from memory output_data
- mem_ready  in  1  from memory ready

Behaviour:
- Reset: state IDLE; all outputs 0 except req_ready=1.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, RELEASE.
- IDLE:
  - req_ready=1.
  - On req_valid, capture req_write/req_addr/req_wdata.
  - Drive mem_read=!req_write, mem_write=req_write, mem_address, mem_input_data.
  - Next state SETUP; req_ready drops the following cycle.
- SETUP:
  - Exactly one cycle with mode, address and data stable and mem_en=0 (setup before enable).
  - Next state ACCESS with mem_en=1.
- ACCESS:
  - mem_en held 1; mode, address and data held stable.
  - On the first cycle mem_ready=1, latch mem_output_data into resp_rdata (reads only; writes leave resp_rdata unchanged).
  - In that same ready cycle, deassert mem_en and go to RELEASE.
- RELEASE:
  - mem_en=0; wait for mem_ready=0.
  - Then pulse resp_valid for 1 cycle, clear mem_read/mem_write, and return to IDLE with req_ready=1.
  - If mem_ready is already 0 on entry, RELEASE lasts 1 cycle.
- Minimum latency, request accept to resp_valid, with mem_ready asserting in the first ACCESS cycle: 4 cycles.
- Back-to-back:
  - A new request can be accepted in the cycle after resp_valid, since IDLE has req_ready=1.
  - No overlap of accesses; mem_en is never high in two consecutive accesses without an intervening mem_en=0 cycle.
- req_valid while not req_ready is ignored; the requester holds it.
- mem_ready=1 already during SETUP is ignored; only ready seen in ACCESS completes the access.
- Never assert mem_read and mem_write simultaneously.
- Reset mid-operation:
  - Immediate return to IDLE; mem_en/mem_read/mem_write=0 next cycle.
  - No resp_valid for the aborted access.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) counts ACCESS cycles.
  - If it reaches TIMEOUT_CYCLES without mem_ready, deassert mem_en, go to RELEASE, and set resp_error=1 with resp_valid.
  - resp_rdata is unchanged on timeout.
  - The counter clears on entry to ACCESS.
- Undefined: no counter; ACCESS waits indefinitely; resp_error tied 0.

Decomposition:
- Shared package mem_if_pkg holds:
  - ADDR_W/DATA_W defaults
  - FSM state enum (IDLE, SETUP, ACCESS, RELEASE) as a 2-bit typedef
  - the MEM_TIMEOUT default constant
- No sub-module; the timeout counter stays inline.

Test Plan:
- Write 8'hFF to addr 7'd1, memory model ready 2 cycles after en:
  - mem_write=1 and mem_address=1 one cycle before mem_en rises.
  - mem_en drops the cycle after ready.
  - resp_valid pulses once, resp_error=0.
- Read addr 7'd1 after that write: resp_rdata=8'hFF with resp_valid; mem_read=1 and mem_write=0 throughout the access.
- Two back-to-back requests (write 8'hA5 @7'd3, read @7'd3) with req_valid held high:
  - Second accepted the cycle after the first resp_valid.
  - mem_en low for ≥1 cycle between accesses.
  - resp_rdata=8'hA5.
- Reset asserted during ACCESS of a read: next cycle mem_en=0, req_ready=1, and no resp_valid follows.
- MEM_TIMEOUT_EN defined, mem_ready held 0: mem_en drops after 16 ACCESS cycles; resp_valid=1 with resp_error=1. Macro undefined: mem_en stays high and there is no response.
- mem_ready stuck high across accesses: RELEASE holds until ready falls, then resp_valid; no new mem_en before that.
